wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Write-back/commit stage that produces the register-file write port (write enable, destination address, write data) consumed by the 32x32 integer register file.
- Accepts retiring instructions from the memory stage over a valid/ready handshake and selects the result source: ALU, load data, or PC+4.
- For loads, it waits for the data-memory response, then extracts, aligns and sign/zero-extends the data.
- Exposes the committed result as a forwarding tap and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RAW, 5, register address width; 32 architectural registers.
- CNTW, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  unit can accept this cycle.
- in_inst  in  32  instruction word; rd=[11:7], funct3=[14:12].
- in_alu  in  32  ALU result.
- in_pc4  in  32  PC+4 value.
- in_wbsel  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 reserved (treated as ALU).
- in_regwen  in  1  instruction writes rd.
- in_addr_lo  in  2  byte offset of the load address.
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  32  raw aligned word from data memory.
- rf_wen  out  1  register-file write enable.
- rf_addr  out  5  register-file destination address.
- rf_data  out  32  register-file write data.
- fwd_valid  out  1  equals rf_wen; forwarding tap.
- instret  out  CNTW  count of committed instructions.
- stray_rsp  out  1  sticky: mem_rvalid seen while no load was pending.

Behaviour:
- Reset values:
  - state=IDLE.
  - rf_wen=0, rf_addr=0, rf_data=0, fwd_valid=0.
  - instret=0, stray_rsp=0.
  - in_ready=1 once reset is released.
- States:
  - IDLE: nothing pending.
  - WAIT_MEM: a load has been accepted; its data is outstanding.
  - COMMIT: one cycle of rf_wen output.
- in_ready = (state != WAIT_MEM). It is combinational from state only, never from in_valid.
- Accept occurs when in_valid && in_ready at a rising edge. Latch rd, funct3, wbsel, regwen, addr_lo, alu and pc4.
- Non-load (wbsel != 1), accepted at edge N:
  - Next state is COMMIT.
  - rf_* are registered and valid during cycle N+1, so latency is 1 cycle.
- Load (wbsel == 1), accepted at edge N:
  - Next state is WAIT_MEM.
  - mem_rvalid may already be high in the accept cycle; it is still counted only from cycle N+1 onward.
  - On the edge where mem_rvalid=1 in WAIT_MEM, register the extracted data and go to COMMIT.
- COMMIT lasts exactly one cycle.
  - A new accept in the same cycle goes to COMMIT or WAIT_MEM as above.
  - Otherwise the next state is IDLE.
  - Back-to-back non-loads therefore give rf_wen high every cycle.
- rf_wen = COMMIT && latched regwen && (rd != 0). rf_addr and rf_data are held stable through COMMIT.
- Outside COMMIT, rf_wen=0; rf_addr and rf_data hold their last values.
- Load extraction by funct3:
  - 000 LB: byte at offset addr_lo (bits [8*o+7:8*o]), sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half selected by addr_lo[1] (0 = [15:0], 1 = [31:16]), sign-extended; addr_lo[0] is ignored.
  - 101 LHU: same half, zero-extended.
  - 010 LW and all other codes: full word; addr_lo is ignored.
  - Misalignment never traps.
- instret increments by 1 on every COMMIT cycle, including rd=0 and regwen=0. It wraps modulo 2^CNTW.
- stray_rsp is set when mem_rvalid=1 and state != WAIT_MEM. It is cleared only by reset. The stray data is discarded.
- Reset mid-operation: asserting rst_n=0 in WAIT_MEM drops the pending load, with no write and no instret increment. A response arriving after reset release counts as stray.
- There is no timeout; the unit waits in WAIT_MEM indefinitely.

Decomposition:
- Shared package holds:
  - Write-back select constants WB_ALU=0, WB_MEM=1, WB_PC4=2.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - State encoding IDLE, WAIT_MEM, COMMIT.
  - Instruction field bit positions.
- One combinational sub-module, load_extract: inputs funct3, addr_lo, rdata; output the extended 32-bit value.

Test Plan:
- Non-load: accept inst with rd=5, wbsel=0, in_alu=0x1234_5678, regwen=1 at edge N -> during cycle N+1, rf_wen=1, rf_addr=5, rf_data=0x1234_5678, instret=1.
- LB: accept with funct3=000, addr_lo=2; mem_rdata=0x0080_0000 with rvalid 3 cycles later -> in_ready=0 while waiting; then one cycle with rf_data=0xFFFF_FF80. Repeat as LBU -> rf_data=0x0000_0080.
- LH and LHU: mem_rdata=0x8001_7FFF. LH with addr_lo=2 -> rf_data=0xFFFF_8001. LHU with addr_lo=0 -> rf_data=0x0000_7FFF.
- rd=0: accept JAL with wbsel=2, rd=0 -> rf_wen stays 0; instret still increments.
- Back-to-back: three non-loads on consecutive cycles with rd=1,2,3 -> rf_wen high for 3 consecutive cycles, addresses 1,2,3 in order; in_ready held at 1 throughout.
- Reset and stray: assert rst_n=0 while in WAIT_MEM -> no write; after release, pulse mem_rvalid -> stray_rsp=1, rf_wen=0, instret=0.

Source files
------------

// File: rtl/wb_commit_unit_pkg.sv
// Shared constants for the write-back/commit stage: result-source selects,
// load funct3 codes, FSM encoding and instruction field positions.
package wb_commit_unit_pkg;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int RD_LSB = 7;
   localparam int RD_MSB = 11;
   localparam int F3_LSB = 12;
   localparam int F3_MSB = 14;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_COMMIT   = 2'd2
   } state_e;

endpackage

// File: rtl/wb_commit_unit_load_extract.sv
// Combinational load-data extraction: selects byte/half/word from the raw
// memory word by byte offset and sign- or zero-extends it.
module load_extract
   import wb_commit_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      // Unknown codes fall back to a full word; misalignment never traps.
      case (funct3)
         F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  ext_data = {24'h000000, byte_sel};
         F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  ext_data = {16'h0000, half_sel};
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: accepts retiring instructions, waits for load data
// when needed, and drives a registered register-file write port.
module wb_commit_unit
   import wb_commit_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RAW  = 5,
   parameter int CNTW = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_alu,
   input  logic [XLEN-1:0] in_pc4,
   input  logic [1:0]      in_wbsel,
   input  logic            in_regwen,
   input  logic [1:0]      in_addr_lo,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_wen,
   output logic [RAW-1:0]  rf_addr,
   output logic [XLEN-1:0] rf_data,
   output logic            fwd_valid,
   output logic [CNTW-1:0] instret,
   output logic            stray_rsp
);

   state_e          state_q, state_d;
   logic [RAW-1:0]  rd_q, rd_d;
   logic [2:0]      f3_q, f3_d;
   logic            regwen_q, regwen_d;
   logic [1:0]      addr_lo_q, addr_lo_d;
   logic            rf_wen_q, rf_wen_d;
   logic [RAW-1:0]  rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;
   logic [CNTW-1:0] instret_q, instret_d;
   logic            stray_q, stray_d;

   logic            accept;
   logic [RAW-1:0]  in_rd;
   logic [2:0]      in_f3;
   logic [XLEN-1:0] ext_data;
   logic            unused_inst_bits;

   assign in_rd            = in_inst[RD_MSB:RD_LSB];
   assign in_f3            = in_inst[F3_MSB:F3_LSB];
   assign unused_inst_bits = ^{in_inst[31:F3_MSB+1], in_inst[RD_LSB-1:0]};

   // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
   // in_ready depends on state alone, so the producer may hold in_valid freely.
   assign in_ready = (state_q != ST_WAIT_MEM);
   assign accept   = in_valid && in_ready;

   load_extract u_load_extract (
      .funct3   (f3_q),
      .addr_lo  (addr_lo_q),
      .rdata    (mem_rdata),
      .ext_data (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      f3_d      = f3_q;
      regwen_d  = regwen_q;
      addr_lo_d = addr_lo_q;
      rf_wen_d  = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      instret_d = instret_q;
      stray_d   = stray_q | (mem_rvalid && (state_q != ST_WAIT_MEM));

      case (state_q)
         ST_WAIT_MEM: begin
            if (mem_rvalid) begin
               state_d   = ST_COMMIT;
               rf_wen_d  = regwen_q && (rd_q != '0);
               rf_addr_d = rd_q;
               rf_data_d = ext_data;
               instret_d = instret_q + CNTW'(1);
            end
         end
         default: begin
            if (!accept) begin
               state_d = ST_IDLE;
            end else if (in_wbsel == WB_MEM) begin
               // rf_* keep their last values until the load data arrives.
               state_d   = ST_WAIT_MEM;
               rd_d      = in_rd;
               f3_d      = in_f3;
               regwen_d  = in_regwen;
               addr_lo_d = in_addr_lo;
            end else begin
               state_d   = ST_COMMIT;
               rf_wen_d  = in_regwen && (in_rd != '0);
               rf_addr_d = in_rd;
               rf_data_d = (in_wbsel == WB_PC4) ? in_pc4 : in_alu;
               instret_d = instret_q + CNTW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rd_q      <= '0;
         f3_q      <= '0;
         regwen_q  <= 1'b0;
         addr_lo_q <= '0;
         rf_wen_q  <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         instret_q <= '0;
         stray_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         f3_q      <= f3_d;
         regwen_q  <= regwen_d;
         addr_lo_q <= addr_lo_d;
         rf_wen_q  <= rf_wen_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         instret_q <= instret_d;
         stray_q   <= stray_d;
      end
   end

   assign rf_wen    = rf_wen_q;
   assign fwd_valid = rf_wen_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;
   assign instret   = instret_q;
   assign stray_rsp = stray_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit with hand-computed expected values.
module tb_wb_commit_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_alu;
   logic [31:0] in_pc4;
   logic [1:0]  in_wbsel;
   logic        in_regwen;
   logic [1:0]  in_addr_lo;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_wen;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        fwd_valid;
   logic [63:0] instret;
   logic        stray_rsp;

   int checks   = 0;
   int failures = 0;

   wb_commit_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_inst    (in_inst),
      .in_alu     (in_alu),
      .in_pc4     (in_pc4),
      .in_wbsel   (in_wbsel),
      .in_regwen  (in_regwen),
      .in_addr_lo (in_addr_lo),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rf_wen     (rf_wen),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data),
      .fwd_valid  (fwd_valid),
      .instret    (instret),
      .stray_rsp  (stray_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [2:0] f3);
      mk_inst = {17'h0, f3, rd, 7'h03};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] wbsel,
                        input logic regwen, input logic [1:0] lo,
                        input logic [31:0] alu, input logic [31:0] pc4);
      in_valid   = 1'b1;
      in_inst    = mk_inst(rd, f3);
      in_wbsel   = wbsel;
      in_regwen  = regwen;
      in_addr_lo = lo;
      in_alu     = alu;
      in_pc4     = pc4;
   endtask

   task automatic check_wr(input string tag, input logic wen, input logic [4:0] addr,
                           input logic [31:0] data, input logic [63:0] cnt);
      check({tag, "_wen"}, {63'h0, rf_wen}, {63'h0, wen});
      check({tag, "_fwd"}, {63'h0, fwd_valid}, {63'h0, wen});
      check({tag, "_addr"}, {59'h0, rf_addr}, {59'h0, addr});
      check({tag, "_data"}, {32'h0, rf_data}, {32'h0, data});
      check({tag, "_instret"}, instret, cnt);
   endtask

   // A load accepted now, answered after `gap` idle waiting cycles.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] word, input int gap,
                          input logic [31:0] exp_data, input logic [63:0] exp_cnt);
      drive(rd, f3, 2'd1, 1'b1, lo, 32'hDEAD_0000, 32'hDEAD_0004);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         check({tag, "_wait_ready"}, {63'h0, in_ready}, 64'h0);
         check({tag, "_wait_wen"}, {63'h0, rf_wen}, 64'h0);
         tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      check_wr(tag, 1'b1, rd, exp_data, exp_cnt);
      check({tag, "_ready"}, {63'h0, in_ready}, 64'h1);
      tick();
      check({tag, "_after_wen"}, {63'h0, rf_wen}, 64'h0);
      check({tag, "_after_data"}, {32'h0, rf_data}, {32'h0, exp_data});
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_inst    = 32'h0;
      in_alu     = 32'h0;
      in_pc4     = 32'h0;
      in_wbsel   = 2'd0;
      in_regwen  = 1'b0;
      in_addr_lo = 2'd0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_wr("reset", 1'b0, 5'd0, 32'h0, 64'd0);
      check("reset_stray", {63'h0, stray_rsp}, 64'h0);
      check("reset_ready", {63'h0, in_ready}, 64'h1);

      // Non-load ALU result, one-cycle latency.
      drive(5'd5, 3'b000, 2'd0, 1'b1, 2'd0, 32'h1234_5678, 32'h0);
      tick();
      in_valid = 1'b0;
      check_wr("alu", 1'b1, 5'd5, 32'h1234_5678, 64'd1);
      check("alu_ready", {63'h0, in_ready}, 64'h1);
      tick();
      check_wr("alu_idle", 1'b0, 5'd5, 32'h1234_5678, 64'd1);

      do_load("lb",  5'd7,  3'b000, 2'd2, 32'h0080_0000, 2, 32'hFFFF_FF80, 64'd2);
      do_load("lbu", 5'd8,  3'b100, 2'd2, 32'h0080_0000, 2, 32'h0000_0080, 64'd3);
      do_load("lh",  5'd10, 3'b001, 2'd2, 32'h8001_7FFF, 1, 32'hFFFF_8001, 64'd4);
      do_load("lhu", 5'd11, 3'b101, 2'd0, 32'h8001_7FFF, 1, 32'h0000_7FFF, 64'd5);
      do_load("lw",  5'd12, 3'b010, 2'd3, 32'h8001_7FFF, 0, 32'h8001_7FFF, 64'd6);
      do_load("lb3", 5'd13, 3'b000, 2'd3, 32'h7F01_7FFF, 0, 32'h0000_007F, 64'd7);
      check("loads_stray", {63'h0, stray_rsp}, 64'h0);

      // JAL to x0 then JAL to x9, back to back.
      drive(5'd0, 3'b000, 2'd2, 1'b1, 2'd0, 32'h0, 32'h0000_0100);
      tick();
      check("jal0_wen", {63'h0, rf_wen}, 64'h0);
      check("jal0_fwd", {63'h0, fwd_valid}, 64'h0);
      check("jal0_instret", instret, 64'd8);
      drive(5'd9, 3'b000, 2'd2, 1'b1, 2'd0, 32'h5555_5555, 32'h0000_0204);
      tick();
      in_valid = 1'b0;
      check_wr("jal9", 1'b1, 5'd9, 32'h0000_0204, 64'd9);
      tick();

      // Three consecutive non-loads; the third uses the reserved select.
      drive(5'd1, 3'b000, 2'd0, 1'b1, 2'd0, 32'h0000_0011, 32'h0);
      tick();
      check_wr("b2b1", 1'b1, 5'd1, 32'h0000_0011, 64'd10);
      check("b2b1_ready", {63'h0, in_ready}, 64'h1);
      drive(5'd2, 3'b000, 2'd0, 1'b1, 2'd0, 32'h0000_0022, 32'h0);
      tick();
      check_wr("b2b2", 1'b1, 5'd2, 32'h0000_0022, 64'd11);
      check("b2b2_ready", {63'h0, in_ready}, 64'h1);
      drive(5'd3, 3'b000, 2'd3, 1'b1, 2'd0, 32'h0000_0033, 32'h0000_0999);
      tick();
      in_valid = 1'b0;
      check_wr("b2b3", 1'b1, 5'd3, 32'h0000_0033, 64'd12);
      check("b2b3_ready", {63'h0, in_ready}, 64'h1);
      tick();
      check_wr("b2b_idle", 1'b0, 5'd3, 32'h0000_0033, 64'd12);

      // regwen=0 still retires.
      drive(5'd4, 3'b000, 2'd0, 1'b0, 2'd0, 32'h0000_0044, 32'h0);
      tick();
      in_valid = 1'b0;
      check("nowen_wen", {63'h0, rf_wen}, 64'h0);
      check("nowen_instret", instret, 64'd13);
      tick();

      // Reset while a load is pending, then a stray response.
      drive(5'd6, 3'b000, 2'd1, 1'b1, 2'd0, 32'h0, 32'h0);
      tick();
      in_valid = 1'b0;
      check("rst_wait_ready", {63'h0, in_ready}, 64'h0);
      rst_n = 1'b0;
      #1;
      check_wr("rst_mid", 1'b0, 5'd0, 32'h0, 64'd0);
      check("rst_mid_ready", {63'h0, in_ready}, 64'h1);
      tick();
      rst_n = 1'b1;
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_DEAD;
      tick();
      mem_rvalid = 1'b0;
      check("stray_set", {63'h0, stray_rsp}, 64'h1);
      check_wr("stray", 1'b0, 5'd0, 32'h0, 64'd0);
      tick();
      tick();
      check("stray_sticky", {63'h0, stray_rsp}, 64'h1);
      check("stray_ready", {63'h0, in_ready}, 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
